// File: rtl/disable_watchdog.sv
// disable_watchdog
//   Initiator side of the job-abort ("disable") handshake. Watches a target's
//   start/done pulses, counts cycles while a job is in flight and, on overrun,
//   raises a level kill request until the target acknowledges it. If the
//   acknowledge does not arrive within ACK_LIMIT cycles, a sticky error is
//   flagged until enable is dropped.
//
//   Optional build macro: WDOG_KILL_COUNT_EN adds the kill_count port and an
//   8-bit saturating count of acknowledged kills.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   watchdog armed; low returns to IDLE
//   tgt_start    in   pulse: target began a job
//   tgt_done     in   pulse: target finished normally
//   tgt_kill_ack in   target has aborted (pulse or level)
//   tgt_kill     out  kill request, held until ack / error / disable
//   busy         out  high while watching or killing
//   error        out  sticky: kill was never acknowledged
//   elapsed      out  cycle count of the in-flight job
//   kill_count   out  saturating acknowledged-kill count (macro only)
module disable_watchdog #(
   parameter int TIMEOUT   = 4,
   parameter int ACK_LIMIT = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             tgt_start,
   input  logic             tgt_done,
   input  logic             tgt_kill_ack,
   output logic             tgt_kill,
   output logic             busy,
   output logic             error,
   output logic [CNT_W-1:0] elapsed
`ifdef WDOG_KILL_COUNT_EN
   ,
   output logic [7:0]       kill_count
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ACK_MAX_C = CNT_W'(ACK_LIMIT - 1);

   typedef enum logic [1:0] {IDLE, WATCH, KILL, ERROR} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] elapsed_q;
   logic [CNT_W-1:0] ack_cnt_q;
   logic             tgt_kill_q;
   logic             busy_q;
   logic             error_q;
`ifdef WDOG_KILL_COUNT_EN
   logic [7:0]       kill_count_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         elapsed_q    <= '0;
         ack_cnt_q    <= '0;
         tgt_kill_q   <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef WDOG_KILL_COUNT_EN
         kill_count_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // Stray done/ack pulses are ignored here.
               if (enable && tgt_start) begin
                  state_q   <= WATCH;
                  elapsed_q <= CNT_W'(1);
                  busy_q    <= 1'b1;
               end
            end
            WATCH: begin
               // Done beats the timeout when both land on the same edge.
               if (!enable || tgt_done) begin
                  state_q   <= IDLE;
                  elapsed_q <= '0;
                  busy_q    <= 1'b0;
               end else if (elapsed_q == TIMEOUT_C) begin
                  state_q    <= KILL;
                  ack_cnt_q  <= '0;
                  tgt_kill_q <= 1'b1;
               end else begin
                  elapsed_q <= elapsed_q + CNT_W'(1);
               end
            end
            KILL: begin
               if (!enable) begin
                  state_q    <= IDLE;
                  elapsed_q  <= '0;
                  tgt_kill_q <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (tgt_kill_ack) begin
                  state_q    <= IDLE;
                  elapsed_q  <= '0;
                  tgt_kill_q <= 1'b0;
                  busy_q     <= 1'b0;
`ifdef WDOG_KILL_COUNT_EN
                  if (kill_count_q != 8'hFF) kill_count_q <= kill_count_q + 8'd1;
`endif
               end else if (ack_cnt_q == ACK_MAX_C) begin
                  // Target never answered: drop the request and latch error.
                  state_q    <= ERROR;
                  tgt_kill_q <= 1'b0;
                  busy_q     <= 1'b0;
                  error_q    <= 1'b1;
               end else begin
                  ack_cnt_q <= ack_cnt_q + CNT_W'(1);
               end
            end
            ERROR: begin
               if (!enable) begin
                  state_q   <= IDLE;
                  elapsed_q <= '0;
                  error_q   <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               elapsed_q  <= '0;
               tgt_kill_q <= 1'b0;
               busy_q     <= 1'b0;
               error_q    <= 1'b0;
            end
         endcase
      end
   end

   assign tgt_kill = tgt_kill_q;
   assign busy     = busy_q;
   assign error    = error_q;
   assign elapsed  = elapsed_q;
`ifdef WDOG_KILL_COUNT_EN
   assign kill_count = kill_count_q;
`endif

endmodule

// File: tb/tb_disable_watchdog.sv
// Bench for disable_watchdog: each driven cycle pushes the expected registered
// outputs onto a scoreboard queue; the entry is popped and compared after the
// clock edge. Directed checks cover the timing points of interest.
module tb_disable_watchdog;
   localparam int TIMEOUT   = 4;
   localparam int ACK_LIMIT = 8;
   localparam int CNT_W     = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0, tgt_start = 1'b0, tgt_done = 1'b0, tgt_kill_ack = 1'b0;
   logic tgt_kill, busy, error;
   logic [CNT_W-1:0] elapsed;
   logic [7:0] kill_count;

   disable_watchdog #(.TIMEOUT(TIMEOUT), .ACK_LIMIT(ACK_LIMIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tgt_start(tgt_start),
      .tgt_done(tgt_done), .tgt_kill_ack(tgt_kill_ack), .tgt_kill(tgt_kill),
      .busy(busy), .error(error), .elapsed(elapsed)
`ifdef WDOG_KILL_COUNT_EN
      , .kill_count(kill_count)
`endif
   );
`ifndef WDOG_KILL_COUNT_EN
   assign kill_count = 8'd0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic       kill;
      logic       busy;
      logic       err;
      logic [7:0] el;
      logic [7:0] kc;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_pass = 0;

   // reference model state: 0 IDLE, 1 WATCH, 2 KILL, 3 ERROR
   int m_st = 0, m_el = 0, m_ack = 0, m_kc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_st = 0; m_el = 0; m_ack = 0; m_kc = 0;
   endtask

   task automatic model_step(input logic en, input logic st, input logic dn, input logic ak);
      case (m_st)
         0: if (en && st) begin m_st = 1; m_el = 1; end
         1: begin
            if (!en || dn) begin m_st = 0; m_el = 0; end
            else if (m_el == TIMEOUT) begin m_st = 2; m_ack = 0; end
            else m_el++;
         end
         2: begin
            if (!en) begin m_st = 0; m_el = 0; end
            else if (ak) begin
               m_st = 0; m_el = 0;
               if (m_kc < 255) m_kc++;
            end else if (m_ack == ACK_LIMIT - 1) m_st = 3;
            else m_ack++;
         end
         default: if (!en) begin m_st = 0; m_el = 0; end
      endcase
   endtask

   task automatic cycle(input string tag, input logic en, input logic st,
                        input logic dn, input logic ak);
      exp_t e;
      enable = en; tgt_start = st; tgt_done = dn; tgt_kill_ack = ak;
      model_step(en, st, dn, ak);
      e.kill = (m_st == 2);
      e.busy = (m_st == 1) || (m_st == 2);
      e.err  = (m_st == 3);
      e.el   = 8'(m_el);
      e.kc   = 8'(m_kc);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, "_kill"}, 32'(tgt_kill), 32'(e.kill));
      chk({tag, "_busy"}, 32'(busy),     32'(e.busy));
      chk({tag, "_err"},  32'(error),    32'(e.err));
      chk({tag, "_el"},   32'(elapsed),  32'(e.el));
`ifdef WDOG_KILL_COUNT_EN
      chk({tag, "_kc"},   32'(kill_count), 32'(e.kc));
`endif
      tgt_start = 1'b0; tgt_done = 1'b0; tgt_kill_ack = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_kill"}, 32'(tgt_kill), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_err"},  32'(error), 0);
      chk({tag, "_el"},   32'(elapsed), 0);
      chk({tag, "_kc"},   32'(kill_count), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0; tgt_start = 1'b0; tgt_done = 1'b0; tgt_kill_ack = 1'b0;
      model_reset();
      #2;
      check_reset_vals("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Timeout then acknowledged kill.
      cycle("t1_e0", 1, 1, 0, 0);
      chk("t1_busy_e0", 32'(busy), 1);
      for (int i = 1; i < TIMEOUT; i++) cycle("t1_w", 1, 0, 0, 0);
      chk("t1_nokill_e3", 32'(tgt_kill), 0);
      cycle("t1_e4", 1, 0, 0, 0);
      chk("t1_kill_e4", 32'(tgt_kill), 1);
      chk("t1_el_e4", 32'(elapsed), TIMEOUT);
      cycle("t1_e5", 1, 0, 1, 0);  // done in KILL ignored
      chk("t1_kill_e5", 32'(tgt_kill), 1);
      cycle("t1_e6", 1, 0, 0, 1);
      chk("t1_kill_e6", 32'(tgt_kill), 0);
      chk("t1_busy_e6", 32'(busy), 0);
`ifdef WDOG_KILL_COUNT_EN
      chk("t1_kc", 32'(kill_count), 1);
`endif

      // Done on the timeout edge wins.
      cycle("t2_e0", 1, 1, 0, 0);
      for (int i = 1; i < TIMEOUT; i++) cycle("t2_w", 1, i == 2, 0, 0);  // restart ignored
      cycle("t2_e4", 1, 0, 1, 0);
      chk("t2_kill", 32'(tgt_kill), 0);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_el", 32'(elapsed), 0);

      // Ack never arrives -> error, cleared only by enable low.
      cycle("t3_e0", 1, 1, 0, 0);
      for (int i = 0; i < TIMEOUT; i++) cycle("t3_w", 1, 0, 0, 0);
      for (int i = 0; i < ACK_LIMIT - 1; i++) cycle("t3_k", 1, 0, 0, 0);
      chk("t3_kill_held", 32'(tgt_kill), 1);
      cycle("t3_lim", 1, 0, 0, 0);
      chk("t3_err", 32'(error), 1);
      chk("t3_kill_off", 32'(tgt_kill), 0);
      cycle("t3_sticky", 1, 1, 0, 1);
      chk("t3_err_sticky", 32'(error), 1);
      cycle("t3_dis", 0, 0, 0, 0);
      chk("t3_err_clr", 32'(error), 0);

      // Enable dropped mid-watch; stray done/ack in IDLE ignored.
      cycle("t4_e0", 1, 1, 0, 0);
      cycle("t4_e1", 1, 0, 0, 0);
      chk("t4_el2", 32'(elapsed), 2);
      cycle("t4_dis", 0, 0, 0, 0);
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_idle_el", 32'(elapsed), 0);
      cycle("t4_done", 1, 0, 1, 0);
      cycle("t4_ack", 1, 0, 0, 1);
      for (int i = 0; i < 8; i++) cycle("t4_q", 1, 0, 0, 0);
      chk("t4_nokill", 32'(tgt_kill), 0);

      // Enable dropped in KILL.
      cycle("t5_e0", 1, 1, 0, 0);
      for (int i = 0; i < TIMEOUT; i++) cycle("t5_w", 1, 0, 0, 0);
      cycle("t5_dis", 0, 0, 0, 0);
      chk("t5_kill_off", 32'(tgt_kill), 0);

      // Asynchronous reset while killing.
      cycle("t6_e0", 1, 1, 0, 0);
      for (int i = 0; i < TIMEOUT; i++) cycle("t6_w", 1, 0, 0, 0);
      chk("t6_kill_on", 32'(tgt_kill), 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_vals("t6_async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         cycle("rnd", $urandom_range(0, 15) != 0, ($urandom % 4) == 0,
               ($urandom % 6) == 0, ($urandom % 4) == 0);

      // Saturation of the acknowledged-kill count.
      do_reset();
      for (int j = 0; j < 260; j++) begin
         cycle("sat_s", 1, 1, 0, 0);
         for (int i = 0; i < TIMEOUT; i++) cycle("sat_w", 1, 0, 0, 0);
         cycle("sat_a", 1, 0, 0, 1);
      end
`ifdef WDOG_KILL_COUNT_EN
      chk("sat_kc", 32'(kill_count), 255);
`endif
      chk("sat_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
